// File: rtl/gpr_mp_if.sv
// Bus between gpr_mp and its decode (read/issue) and writeback (write) clients.
interface gpr_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  // No per-transfer handshake: ready is a level that rises once after the
  // reset sweep. Reads are always combinational, and every enable is a
  // single-cycle strobe that the register file accepts unconditionally
  // while ready is high. While ready is low, all strobes are ignored.
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we0;
  logic [ADDR_W-1:0]        wr_addr0;
  logic [DATA_W-1:0]        wr_data0;
  logic                     we1;
  logic [ADDR_W-1:0]        wr_addr1;
  logic [DATA_W-1:0]        wr_data1;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, we0, wr_addr0, wr_data0, we1, wr_addr1, wr_data1,
           issue_en, issue_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, we0, wr_addr0, wr_data0, we1, wr_addr1, wr_data1,
           issue_en, issue_addr
  );
endinterface

// File: rtl/gpr_mp.sv
// Multi-port register file with dual write ports, busy scoreboard and a
// zero-init sweep after reset. Optional same-cycle write bypass: GPR_MP_BYPASS_EN.
module gpr_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     reset,
  gpr_mp_if.slave  bus,
  output logic     state_dbg
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy;

  logic run, wr_ok0, wr_ok1, iss_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Gating with reset makes the outputs quiet during the reset cycle itself.
  assign run    = (state == RUN) && !reset;
  assign wr_ok0 = run && bus.we0 && ((bus.wr_addr0 != '0) || (ZERO_REG == 0));
  assign wr_ok1 = run && bus.we1 && ((bus.wr_addr1 != '0) || (ZERO_REG == 0));
  assign iss_ok = run && bus.issue_en && ((bus.issue_addr != '0) || (ZERO_REG == 0));

  // Port 1 is assigned last so it wins a same-address write.
  always_ff @(posedge clk) begin
    if (!reset && state == INIT) mem[cnt] <= '0;
    if (wr_ok0) mem[bus.wr_addr0] <= bus.wr_data0;
    if (wr_ok1) mem[bus.wr_addr1] <= bus.wr_data1;
  end

  // Set after clear: a newer producer stays outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_ok0) busy[bus.wr_addr0] <= 1'b0;
      if (wr_ok1) busy[bus.wr_addr1] <= 1'b0;
      if (iss_ok) busy[bus.issue_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      automatic logic [ADDR_W-1:0] ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (run) begin
        rd_busy_c[k] = busy[ra];
        if (!((ZERO_REG != 0) && (ra == '0))) begin
          rd_data_c[k*DATA_W +: DATA_W] = mem[ra];
`ifdef GPR_MP_BYPASS_EN
          if (wr_ok0 && (bus.wr_addr0 == ra)) rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data0;
          if (wr_ok1 && (bus.wr_addr1 == ra)) rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data1;
`endif
        end
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;
  assign bus.ready   = ready_q && !reset;
  assign state_dbg   = (state == RUN);
endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: default instance plus a 64-bit/8-entry/4-port
// instance. Expectations follow GPR_MP_BYPASS_EN when it is defined.
module tb_gpr_mp;
  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic dbg_a, dbg_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  gpr_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  gpr_mp_if #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4)) bus_b ();

  gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.slave), .state_dbg(dbg_a));
  gpr_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.slave), .state_dbg(dbg_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we0 = 0; bus_a.we1 = 0; bus_a.issue_en = 0;
    bus_a.wr_addr0 = '0; bus_a.wr_addr1 = '0; bus_a.issue_addr = '0;
    bus_a.wr_data0 = '0; bus_a.wr_data1 = '0;
  endtask

  task automatic idle_b();
    bus_b.we0 = 0; bus_b.we1 = 0; bus_b.issue_en = 0;
    bus_b.wr_addr0 = '0; bus_b.wr_addr1 = '0; bus_b.issue_addr = '0;
    bus_b.wr_data0 = '0; bus_b.wr_data1 = '0; bus_b.rd_addr = '0;
  endtask

  // Counts edges until ready rises on instance a, bounded.
  task automatic wait_ready_a(output int n);
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    idle_a();
    bus_a.rd_addr = {5'd3, 5'd5};
    tick(); tick();
    n_tests++;
    if (bus_a.ready !== 1'b0 || bus_a.rd_data !== '0 || bus_a.rd_busy !== '0 || dbg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rd_data=%h rd_busy=%b state=%b, required 0/0/0/0",
               bus_a.ready, bus_a.rd_data, bus_a.rd_busy, dbg_a);
    end
  endtask

  task automatic test_init_sweep();
    int n;
    tick();
    reset_a = 1'b0;
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd5; bus_a.wr_data0 = 32'hDEADBEEF;
    bus_a.rd_addr = {5'd5, 5'd5};
    #1;
    n_tests++;
    if (bus_a.ready !== 1'b0 || bus_a.rd_data !== '0) begin
      n_fail++;
      $display("FAIL init_outputs: ready=%b rd_data=%h, required 0/0", bus_a.ready, bus_a.rd_data);
    end
    wait_ready_a(n);
    bus_a.we0 = 0;
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL init_length: ready after %0d cycles, required 32", n);
    end
    n_tests++;
    if (bus_a.rd_data[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL init_r5: read %h, required 00000000", bus_a.rd_data[31:0]);
    end
  endtask

  task automatic test_write_read();
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd3; bus_a.wr_data0 = 32'h12345678;
    bus_a.we1 = 1; bus_a.wr_addr1 = 5'd0; bus_a.wr_data1 = 32'hFFFFFFFF;
    tick();
    idle_a();
    bus_a.rd_addr = {5'd3, 5'd3};
    #1;
    n_tests++;
    if (bus_a.rd_data !== {32'h12345678, 32'h12345678}) begin
      n_fail++;
      $display("FAIL read_r3_both: got %h, required 1234567812345678", bus_a.rd_data);
    end
    bus_a.rd_addr = {5'd0, 5'd0};
    #1;
    n_tests++;
    if (bus_a.rd_data !== '0) begin
      n_fail++;
      $display("FAIL read_r0: got %h, required 0", bus_a.rd_data);
    end
    bus_a.we1 = 1; bus_a.wr_addr1 = 5'd10; bus_a.wr_data1 = 32'hCAFEF00D;
    tick();
    idle_a();
    bus_a.rd_addr = {5'd10, 5'd3};
    #1;
    n_tests++;
    if (bus_a.rd_data !== {32'hCAFEF00D, 32'h12345678}) begin
      n_fail++;
      $display("FAIL read_r10_r3: got %h, required cafef00d12345678", bus_a.rd_data);
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] exp_same;
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd7; bus_a.wr_data0 = 32'h11111111;
    tick();
`ifdef GPR_MP_BYPASS_EN
    exp_same = 32'h0000BBBB;
`else
    exp_same = 32'h11111111;
`endif
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd7; bus_a.wr_data0 = 32'hAAAA0000;
    bus_a.we1 = 1; bus_a.wr_addr1 = 5'd7; bus_a.wr_data1 = 32'h0000BBBB;
    bus_a.rd_addr = {5'd3, 5'd7};
    #1;
    n_tests++;
    if (bus_a.rd_data[31:0] !== exp_same) begin
      n_fail++;
      $display("FAIL dual_same_cycle: got %h, required %h", bus_a.rd_data[31:0], exp_same);
    end
    tick();
    idle_a();
    #1;
    n_tests++;
    if (bus_a.rd_data[31:0] !== 32'h0000BBBB) begin
      n_fail++;
      $display("FAIL dual_r7: got %h, required 0000bbbb", bus_a.rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    bus_a.rd_addr = {5'd0, 5'd9};
    bus_a.issue_en = 1; bus_a.issue_addr = 5'd9;
    #1;
    n_tests++;
    if (bus_a.rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_no_bypass: got %b, required 0", bus_a.rd_busy[0]);
    end
    tick();
    idle_a();
    n_tests++;
    if (bus_a.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_set: got %b, required 1", bus_a.rd_busy[0]);
    end
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd9; bus_a.wr_data0 = 32'h99;
    #1;
    n_tests++;
    if (bus_a.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold_write_cycle: got %b, required 1", bus_a.rd_busy[0]);
    end
    tick();
    idle_a();
    n_tests++;
    if (bus_a.rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_clear: got %b, required 0", bus_a.rd_busy[0]);
    end
    bus_a.issue_en = 1; bus_a.issue_addr = 5'd9;
    bus_a.we1 = 1; bus_a.wr_addr1 = 5'd9; bus_a.wr_data1 = 32'h98;
    tick();
    idle_a();
    n_tests++;
    if (bus_a.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_set_wins: got %b, required 1", bus_a.rd_busy[0]);
    end
    bus_a.we1 = 1; bus_a.wr_addr1 = 5'd9; bus_a.wr_data1 = 32'h97;
    bus_a.issue_en = 1; bus_a.issue_addr = 5'd0;
    tick();
    idle_a();
    n_tests++;
    if (bus_a.rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_r0_and_port1_clear: got %b, required 00", bus_a.rd_busy);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd4; bus_a.wr_data0 = 32'h55;
    bus_a.issue_en = 1; bus_a.issue_addr = 5'd4;
    bus_a.rd_addr = {5'd4, 5'd4};
    tick();
    idle_a();
    n_tests++;
    if (bus_a.rd_data[31:0] !== 32'h55 || bus_a.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_r4: data=%h busy=%b, required 00000055/1",
               bus_a.rd_data[31:0], bus_a.rd_busy[0]);
    end
    reset_a = 1'b1;
    bus_a.we0 = 1; bus_a.wr_addr0 = 5'd4; bus_a.wr_data0 = 32'h77;
    #1;
    n_tests++;
    if (bus_a.ready !== 1'b0 || bus_a.rd_busy !== '0 || bus_a.rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_pulse: ready=%b busy=%b data=%h, required 0/0/0",
               bus_a.ready, bus_a.rd_busy, bus_a.rd_data);
    end
    tick();
    reset_a = 1'b0;
    idle_a();
    wait_ready_a(n);
    n_tests++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL reinit_length: ready after %0d cycles, required 32", n);
    end
    n_tests++;
    if (bus_a.rd_data[31:0] !== 32'h0 || bus_a.rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit_r4: data=%h busy=%b, required 0/0",
               bus_a.rd_data[31:0], bus_a.rd_busy[0]);
    end
  endtask

  task automatic test_param_sweep();
    int n;
    logic [63:0] exp [4];
    idle_b();
    tick();
    reset_b = 1'b0;
    n = 0;
    while (bus_b.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL sweep_init_length: ready after %0d cycles, required 8", n);
    end
    bus_b.we0 = 1; bus_b.wr_addr0 = 3'd1; bus_b.wr_data0 = 64'hFFFFFFFF00000001;
    bus_b.we1 = 1; bus_b.wr_addr1 = 3'd2; bus_b.wr_data1 = 64'h0123456789ABCDEF;
    tick();
    bus_b.we0 = 1; bus_b.wr_addr0 = 3'd3; bus_b.wr_data0 = 64'h8000000000000000;
    bus_b.we1 = 1; bus_b.wr_addr1 = 3'd7; bus_b.wr_data1 = 64'h00000000FFFFFFFE;
    tick();
    idle_b();
    bus_b.rd_addr = {3'd7, 3'd3, 3'd2, 3'd1};
    exp[0] = 64'hFFFFFFFF00000001;
    exp[1] = 64'h0123456789ABCDEF;
    exp[2] = 64'h8000000000000000;
    exp[3] = 64'h00000000FFFFFFFE;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus_b.rd_data[k*64 +: 64] !== exp[k]) begin
        n_fail++;
        $display("FAIL sweep_port%0d: got %h, required %h", k, bus_b.rd_data[k*64 +: 64], exp[k]);
      end
    end
    bus_b.rd_addr = {3'd0, 3'd6, 3'd1, 3'd2};
    #1;
    n_tests++;
    if (bus_b.rd_data !== {64'h0, 64'h0, 64'hFFFFFFFF00000001, 64'h0123456789ABCDEF}) begin
      n_fail++;
      $display("FAIL sweep_reorder: got %h", bus_b.rd_data);
    end
  endtask

  initial begin
    idle_a();
    idle_b();
    bus_a.rd_addr = '0;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_mid_reset();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpr_mp.md
# gpr_mp

Parametrised multi-port general-purpose register file for the next-generation CPU core. It replaces the fixed 2-read/1-write register file with configurable width, depth and read-port count, and adds a second write port and a per-register busy scoreboard. After reset it runs a hardware zero-initialisation sweep, so register contents are defined. It sits between the decode stage (reads, issue) and the writeback stage (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ready  out  1  high once the init sweep completes
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has an outstanding producer
- we0  in  1  write port 0 enable, active-high
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- we1, wr_addr1, wr_data1  in  1/ADDR_W/DATA_W  write port 1; same meaning as port 0
- issue_en  in  1  mark issue_addr busy (instruction issued with this destination)
- issue_addr  in  ADDR_W  destination register being issued

## Operation
- FSM states are INIT and RUN.
  - Reset forces INIT and clears the sweep counter to 0, all busy bits to 0, and ready to 0.
  - INIT writes 0 to register[cnt] each cycle and increments cnt.
  - When cnt == DEPTH-1, that register is written and the FSM moves to RUN next cycle. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - RUN holds until the next reset.
- While in INIT:
  - ready = 0, every rd_data = 0, every rd_busy = 0.
  - we0, we1 and issue_en are ignored.
- In RUN, writes:
  - weN high and (wr_addrN != 0 or ZERO_REG == 0): register[wr_addrN] <= wr_dataN at the clock edge.
  - Both ports writing the same address in one cycle: port 1 wins.
- In RUN, reads are combinational, per port, in priority order:
  1. ZERO_REG and address 0 -> 0.
  2. Bypass, when compiled in (see Configuration).
  3. Otherwise the stored register value.
- Scoreboard, one busy bit per register:
  - issue_en sets busy[issue_addr].
  - A write on either port clears busy[wr_addrN].
  - Set and clear on the same register in the same cycle: set wins (newer producer outstanding).
  - Issue to register 0 with ZERO_REG = 1 is ignored.
  - rd_busy[k] = busy[rd_addr[k]], registered state only (not bypassed by same-cycle issue).
  - A same-cycle write to the address does not clear rd_busy combinationally; it drops the next cycle.
- Reset mid-operation:
  - Contents are overwritten by the new sweep.
  - Busy bits clear immediately at the reset edge.
  - Writes in the reset cycle are discarded.

## Timing
- Read latency: 0 cycles (combinational from rd_addr).
- Write latency: data visible through storage 1 cycle after the weN edge, or same cycle with bypass.
- Busy set/clear visible on rd_busy the cycle after the issue_en or weN edge.
- ready rises on the clock edge that ends the DEPTH-th INIT cycle. With default parameters: 32 cycles after the first clock with reset low.
- Output values while reset is high: ready = 0, rd_data = 0, rd_busy = 0.

## Configuration
- GPR_MP_BYPASS_EN defined:
  - A read whose address matches an active write this cycle returns that write's data.
  - If both write ports match, port 1's data is returned.
  - Register 0 is excluded when ZERO_REG = 1.
  - Bypass is inactive in INIT.
- GPR_MP_BYPASS_EN undefined:
  - Reads return stored values only.
  - A write is observed the cycle after its edge.
  - Decode must stall one cycle on a read-after-write to the same register.

## Test plan
- Init sweep:
  - Stimulus: reset for 3 cycles, then release; drive we0 = 1, addr 5, data 0xDEADBEEF during INIT.
  - Required: ready stays 0 for exactly 32 cycles; reading addr 5 after ready returns 0x00000000.
- Write/read with default ZERO_REG:
  - Stimulus: write 0x12345678 to r3 via port 0; write 0xFFFFFFFF to r0.
  - Required: next cycle, read ports 0 and 1 at r3 both return 0x12345678; r0 reads 0.
- Dual-write conflict:
  - Stimulus: in one cycle, port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB, both to r7.
  - Required: r7 = 0x0000BBBB.
  - With GPR_MP_BYPASS_EN defined, the same-cycle read of r7 returns 0x0000BBBB.
  - Without it, the same-cycle read returns the old value and the next cycle returns 0x0000BBBB.
- Scoreboard:
  - Stimulus: issue r9; next cycle, write r9; separately, issue r9 and write r9 in the same cycle.
  - Required: rd_busy for r9 is 1 the cycle after issue and 0 the cycle after the write.
  - Required: simultaneous issue and write of r9 leaves busy = 1.
  - Required: issue r0 leaves busy[0] = 0.
- Reset mid-operation:
  - Stimulus: with r4 = 0x55 and r4 busy, pulse reset for 1 cycle.
  - Required: rd_busy = 0 and ready = 0 immediately; after 32 cycles ready = 1 and r4 reads 0.
- Parameter sweep:
  - Stimulus: DATA_W = 64, ADDR_W = 3, NUM_RD = 4.
  - Required: INIT lasts 8 cycles; all four ports read distinct registers correctly, including a 0xFFFFFFFF00000001 pattern.
